// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode multi-digit
//   seven-segment display. One hex decoder is shared across all digits; the
//   scan visits one digit per refresh slot and keeps every anode off for a
//   short blank window at the start of each slot to suppress ghosting.
//   Display writes land in a shadow register and are copied to the active
//   register only at a frame boundary, so a frame never shows mixed data.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   wr_en      single-cycle write strobe
//   wr_data    hex nibbles, digit i = wr_data[4i+3:4i]
//   wr_mask    per-digit enable, 0 = digit dark
//   pending    shadow holds a write that has not been committed yet
//   frame_done one-cycle pulse after the last digit slot of a frame ends
//   anode      active-low digit select (at most one bit low)
//   cathode    active-low segments, bit6..bit0 = g f e d c b a
//
// Write protocol: wr_en is a fire-and-forget strobe with no back-pressure.
// Every cycle with wr_en=1 captures wr_data/wr_mask; the latest capture
// before a frame boundary is the one that gets committed. A strobe that
// lands on the frame-boundary cycle itself is committed straight to the
// active register and leaves nothing pending.

module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_mask,
  output logic                    pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0]  BLANK_LIM = PS_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Hex glyphs, active low, bit order g f e d c b a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PS_W-1:0]         prescaler;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] active_data;
  logic [NUM_DIGITS-1:0]   active_mask;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_mask;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic [6:0]              cathode_nxt;

  // Pin values are derived from the current counter state and active data
  // only; the shadow never reaches the decoder.
  always_comb begin
    slot_end    = (prescaler == PS_LAST);
    frame_end   = slot_end && (idx == IDX_LAST);
    nib         = active_data[{idx, 2'b00} +: 4];
    anode_nxt   = '1;
    cathode_nxt = 7'h7F;
    if ((prescaler >= BLANK_LIM) && active_mask[idx]) begin
      anode_nxt   = ~(NUM_DIGITS'(1) << idx);
      cathode_nxt = hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      idx         <= '0;
      active_data <= '0;
      active_mask <= '0;
      shadow_data <= '0;
      shadow_mask <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
      anode       <= '1;
      cathode     <= 7'h7F;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + PS_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      frame_done <= frame_end;
      anode      <= anode_nxt;
      cathode    <= cathode_nxt;

      if (wr_en) begin
        shadow_data <= wr_data;
        shadow_mask <= wr_mask;
      end

      // A strobe on the boundary cycle bypasses the shadow; otherwise the
      // boundary commits whatever the shadow holds.
      if (wr_en && frame_end) begin
        active_data <= wr_data;
        active_mask <= wr_mask;
        pending     <= 1'b0;
      end else if (wr_en) begin
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        active_data <= shadow_data;
        active_mask <= shadow_mask;
        pending     <= 1'b0;
      end
    end
  end

endmodule
